fft_sequencer: RTL

//  Parametrised radix-2 DIT FFT control sequencer. It replaces the fixed 32-point sample-in, iteration, stage and

---
 rtl/fft_sequencer_if.sv | 41 ++++
 rtl/fft_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer_if.sv
// Handshake and addressing bundle between the FFT sequencer
// and its driver/datapath (master = driver side, slave = sequencer).
interface fft_sequencer_if #(
  parameter int LOG2N = 5
);
  logic             fft_start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             ld_we;
  logic [LOG2N-1:0] ld_addr;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wb_en;
  logic [LOG2N-1:0] wb_addr_a;
  logic [LOG2N-1:0] wb_addr_b;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] out_addr;
  logic [3:0]       stage_idx;
  logic             busy;
  logic             fft_done;

  modport master (
    output fft_start, abort, in_valid, out_ready,
    input  in_ready, ld_we, ld_addr, rd_en,
    input  rd_addr_a, rd_addr_b, tw_idx, wb_en,
    input  wb_addr_a, wb_addr_b, out_valid, out_addr,
    input  stage_idx, busy, fft_done
  );

  modport slave (
    input  fft_start, abort, in_valid, out_ready,
    output in_ready, ld_we, ld_addr, rd_en,
    output rd_addr_a, rd_addr_b, tw_idx, wb_en,
    output wb_addr_a, wb_addr_b, out_valid, out_addr,
    output stage_idx, busy, fft_done
  );
endinterface

// File: rtl/fft_sequencer.sv
// Radix-2 DIT FFT control sequencer: bit-reversed load,
// per-stage butterfly addressing with drain, natural unload.
module fft_sequencer #(
  parameter int LOG2N    = 5,
  parameter int BFLY_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  fft_sequencer_if.slave bus
);
  localparam int N  = 1 << LOG2N;
  localparam int HW = LOG2N - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t            state, state_nx;
  logic [LOG2N-1:0]  k, k_nx;
  logic [HW-1:0]     j, j_nx;
  logic [3:0]        s, s_nx;
  logic [3:0]        dc, dc_nx;
  logic              done_q, done_nx;

  logic              in_ready_w;
  logic              rd_en_w;
  logic              out_valid_w;
  logic              in_xfer;
  logic              out_xfer;
  logic [LOG2N-1:0]  rev;
  logic [LOG2N-1:0]  jw, span, pos, grp;
  logic [LOG2N-1:0]  a_addr, b_addr;
  logic [HW-1:0]     tw;

  logic [BFLY_LAT-1:0]             dl_en;
  logic [BFLY_LAT-1:0][LOG2N-1:0]  dl_a;
  logic [BFLY_LAT-1:0][LOG2N-1:0]  dl_b;

  // Stream and read strobes; abort kills them in the same cycle.
  assign in_ready_w  = (state == S_LOAD) & ~bus.abort;
  assign rd_en_w     = (state == S_COMP) & ~bus.abort;
  assign out_valid_w = (state == S_UNLOAD) & ~bus.abort;
  assign in_xfer     = in_ready_w & bus.in_valid;
  assign out_xfer    = out_valid_w & bus.out_ready;

  // Bit-reverse the shared sample counter for loading.
  always_comb begin
    rev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      rev[i] = k[LOG2N-1-i];
    end
  end

  // Butterfly operand and twiddle addressing for (s, j).
  always_comb begin
    jw     = LOG2N'(j);
    span   = LOG2N'(1) << s;
    pos    = jw & (span - LOG2N'(1));
    grp    = jw >> s;
    a_addr = (grp << (s + 4'd1)) | pos;
    b_addr = a_addr | span;
    tw     = HW'(pos << (HW - int'(s)));
  end

  // Next-state, counter and done-pulse logic.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    j_nx     = j;
    s_nx     = s;
    dc_nx    = dc;
    done_nx  = 1'b0;
    if (bus.abort) begin
      state_nx = S_IDLE;
      k_nx     = '0;
      j_nx     = '0;
      s_nx     = '0;
      dc_nx    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.fft_start) state_nx = S_LOAD;
        end
        S_LOAD: begin
          if (in_xfer) begin
            k_nx = k + 1'b1;
            if (k == LOG2N'(N - 1)) state_nx = S_COMP;
          end
        end
        S_COMP: begin
          j_nx = j + 1'b1;
          if (&j) state_nx = S_DRAIN;
        end
        S_DRAIN: begin
          if (dc == 4'(BFLY_LAT - 1)) begin
            dc_nx = '0;
            if (s == 4'(LOG2N - 1)) begin
              s_nx     = '0;
              state_nx = S_UNLOAD;
            end else begin
              s_nx     = s + 4'd1;
              state_nx = S_COMP;
            end
          end else begin
            dc_nx = dc + 4'd1;
          end
        end
        S_UNLOAD: begin
          if (out_xfer) begin
            k_nx = k + 1'b1;
            if (k == LOG2N'(N - 1)) begin
              state_nx = S_IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      j      <= '0;
      s      <= '0;
      dc     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      j      <= j_nx;
      s      <= s_nx;
      dc     <= dc_nx;
      done_q <= done_nx;
    end
  end

  // Writeback delay lines; shift every cycle, flushed on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_en <= '0;
      dl_a  <= '0;
      dl_b  <= '0;
    end else if (bus.abort) begin
      dl_en <= '0;
      dl_a  <= '0;
      dl_b  <= '0;
    end else begin
      dl_en[0] <= rd_en_w;
      dl_a[0]  <= bus.rd_addr_a;
      dl_b[0]  <= bus.rd_addr_b;
      for (int i = 1; i < BFLY_LAT; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a[i]  <= dl_a[i-1];
        dl_b[i]  <= dl_b[i-1];
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.ld_we     = in_xfer;
  assign bus.ld_addr   = (state == S_LOAD) ? rev : '0;
  assign bus.rd_en     = rd_en_w;
  assign bus.rd_addr_a = rd_en_w ? a_addr : '0;
  assign bus.rd_addr_b = rd_en_w ? b_addr : '0;
  assign bus.tw_idx    = rd_en_w ? tw : '0;
  assign bus.wb_en     = dl_en[BFLY_LAT-1];
  assign bus.wb_addr_a = dl_a[BFLY_LAT-1];
  assign bus.wb_addr_b = dl_b[BFLY_LAT-1];
  assign bus.out_valid = out_valid_w;
  assign bus.out_addr  = (state == S_UNLOAD) ? k : '0;
  assign bus.stage_idx = s;
  assign bus.busy      = (state != S_IDLE);
  assign bus.fft_done  = done_q;
endmodule
